// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter_pkg
// Description : Shared constants for the IF/LS memory arbiter: FSM state
//               encoding, the NOP instruction and the reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_dmem_arbiter_pkg;

    // FSM state encoding (3-bit)
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_IF_REQ  = 3'd1;
    localparam logic [2:0] c_ST_IF_WAIT = 3'd2;
    localparam logic [2:0] c_ST_LS_REQ  = 3'd3;
    localparam logic [2:0] c_ST_LS_WAIT = 3'd4;

    // addi x0, x0, 0 - returned for a fetch that timed out on the bus
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Reset program counter of the core using this arbiter
    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_cnt
// Description : Saturating 4-bit counter of LS grants made while a fetch is
//               waiting. o_sat tells the arbiter to hand the bus to IF next.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    logic [3:0] r_cnt;

    // Clear has priority; increment stops at MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt != 4'(MAX))) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_sat = (r_cnt == 4'(MAX));

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter
// Description : Shares one 64-bit single-port memory bus between instruction
//               fetch and the load/store unit, one transaction at a time.
//               Fetch responses made stale by a jump redirect are dropped.
//               Optional macro ARB_BUS_TIMEOUT_EN adds a wait-state timeout
//               with a sticky bus_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int STARVE_MAX = 4
`ifdef ARB_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              ifetch_en,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              ls_req,
    input  logic              ls_wen,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [63:0]       ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic [63:0]       ls_rdata,
    output logic              ls_done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              bus_err
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_if_resp;
    logic              w_ls_resp;
    logic              w_starved;
    logic              w_in_if;
    logic              r_stale;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wmask;
    logic              r_ifetch_en;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic              r_ls_done;
    logic [63:0]       r_ls_rdata;
`ifdef ARB_BUS_TIMEOUT_EN
    logic [7:0]        r_wait_cnt;
    logic              w_timeout;
    logic              r_bus_err;
`endif

    assign w_in_if = (r_state == c_ST_IF_REQ) || (r_state == c_ST_IF_WAIT);

    arb_starve_cnt #(
        .MAX   (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_grant_if),
        .i_inc (w_grant_ls && if_req),
        .o_sat (w_starved)
    );

    // Next-state: arbitration in IDLE, bus handshake and response tracking
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_ls  = 1'b0;
        w_if_resp   = 1'b0;
        w_ls_resp   = 1'b0;
`ifdef ARB_BUS_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (if_req && (!ls_req || w_starved)) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = c_ST_IF_REQ;
                end else if (ls_req) begin
                    w_grant_ls  = 1'b1;
                    w_state_nxt = c_ST_LS_REQ;
                end
            end
            c_ST_IF_REQ:  if (mem_ready) w_state_nxt = c_ST_IF_WAIT;
            c_ST_IF_WAIT: begin
                if (mem_rvalid) begin
                    w_if_resp   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_LS_REQ:  if (mem_ready) w_state_nxt = c_ST_LS_WAIT;
            c_ST_LS_WAIT: begin
                if (mem_rvalid) begin
                    w_ls_resp   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:      w_state_nxt = c_ST_IDLE;
        endcase
`ifdef ARB_BUS_TIMEOUT_EN
        // Only a state that is about to stay put can time out
        if ((r_state != c_ST_IDLE) && (w_state_nxt == r_state) &&
            (r_wait_cnt == 8'(TIMEOUT - 1))) begin
            w_timeout   = 1'b1;
            w_state_nxt = c_ST_IDLE;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Capture the granted request; fields stay stable until the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= 64'h0;
            r_wmask <= 8'h0;
        end else if (w_grant_if) begin
            r_addr  <= if_addr;
            r_wen   <= 1'b0;
            r_wdata <= 64'h0;
            r_wmask <= 8'h0;
        end else if (w_grant_ls) begin
            r_addr  <= ls_addr;
            r_wen   <= ls_wen;
            r_wdata <= ls_wdata;
            r_wmask <= ls_wen ? ls_wmask : 8'h0;
        end
    end

    // Stale flag: a redirect during a fetch poisons its response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stale <= 1'b0;
        end else if (w_if_resp) begin
            r_stale <= 1'b0;
`ifdef ARB_BUS_TIMEOUT_EN
        end else if (w_timeout) begin
            r_stale <= 1'b0;
`endif
        end else if (if_flush && w_in_if) begin
            r_stale <= 1'b1;
        end
    end

    // Response side: one-cycle pulses and registered return data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifetch_en   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0;
            r_ls_done     <= 1'b0;
            r_ls_rdata    <= 64'h0;
        end else begin
            r_ifetch_en   <= (r_state == c_ST_IF_REQ) && mem_ready;
            r_instr_valid <= w_if_resp && !r_stale && !if_flush;
            r_ls_done     <= w_ls_resp;
            if (w_if_resp) r_instr    <= r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            if (w_ls_resp) r_ls_rdata <= mem_rdata;
`ifdef ARB_BUS_TIMEOUT_EN
            if (w_timeout) begin
                if (w_in_if) begin
                    r_instr_valid <= 1'b1;
                    r_instr       <= NOP_INSTR;
                end else begin
                    r_ls_done     <= 1'b1;
                    r_ls_rdata    <= 64'h0;
                end
            end
`endif
        end
    end

`ifdef ARB_BUS_TIMEOUT_EN
    // Wait counter: cycles spent in the current non-idle state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                    r_wait_cnt <= 8'd0;
        else if ((r_state == c_ST_IDLE) || (w_state_nxt != r_state)) r_wait_cnt <= 8'd0;
        else                                                        r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    // Sticky bus error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_bus_err <= 1'b0;
        else if (w_timeout) r_bus_err <= 1'b1;
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    assign mem_valid   = (r_state == c_ST_IF_REQ) || (r_state == c_ST_LS_REQ);
    assign mem_wen     = r_wen;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_wmask   = r_wmask;
    assign ifetch_en   = r_ifetch_en;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign ls_rdata    = r_ls_rdata;
    assign ls_done     = r_ls_done;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_arbiter
// Description : Self-checking bench for imem_dmem_arbiter: directed cases
//               followed by random fetch/load/store traffic against a
//               byte-masked reference memory. Covers ARB_BUS_TIMEOUT_EN when
//               that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    localparam int c_STARVE_MAX = 4;

    logic        clk, rst;
    logic        if_req, if_flush, ifetch_en, instr_valid;
    logic [63:0] if_addr;
    logic [31:0] instr;
    logic        ls_req, ls_wen, ls_done;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid, bus_err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_iv  = 0;
    int n_done = 0;
    int rdy_dly = 0;
    int rsp_dly = 0;
    bit resp_en = 1'b1;
    int valid_cycles = 0;
    int lat_en = 0;
    int lat_iv = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } bus_t;

    bus_t        bus_q[$];
    bus_t        rsp_t;
    logic [63:0] bus_mem [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    imem_dmem_arbiter #(
        .ADDR_W     (64),
        .STARVE_MAX (c_STARVE_MAX)
`ifdef ARB_BUS_TIMEOUT_EN
        ,
        .TIMEOUT    (8)
`endif
    ) dut (
        .clk (clk), .rst (rst),
        .if_req (if_req), .if_addr (if_addr), .if_flush (if_flush),
        .ifetch_en (ifetch_en), .instr (instr), .instr_valid (instr_valid),
        .ls_req (ls_req), .ls_wen (ls_wen), .ls_addr (ls_addr),
        .ls_wdata (ls_wdata), .ls_wmask (ls_wmask),
        .ls_rdata (ls_rdata), .ls_done (ls_done),
        .mem_valid (mem_valid), .mem_ready (mem_ready), .mem_wen (mem_wen),
        .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wmask (mem_wmask),
        .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
        .bus_err (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Count output pulses shortly after each edge
    always @(posedge clk) begin
        #1;
        if (instr_valid) n_iv++;
        if (ls_done)     n_done++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [63:0] idx);
        return {idx[31:0] ^ 32'h5A5A_0000, ~idx[31:0]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] bus_rd(input logic [63:0] idx);
        return bus_mem.exists(idx) ? bus_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    // Memory-side bus model: configurable ready and response delays
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
        forever begin
            @(negedge clk);
            if (mem_valid && !rst) begin
                rsp_t = '{addr: mem_addr, wen: mem_wen, wdata: mem_wdata, wmask: mem_wmask};
                bus_q.push_back(rsp_t);
                valid_cycles = 1;
                for (int i = 0; i < rdy_dly; i++) begin
                    @(negedge clk);
                    valid_cycles++;
                    check("bus_hold", {mem_valid, mem_wen, mem_wmask, mem_addr, mem_wdata},
                          {1'b1, rsp_t.wen, rsp_t.wmask, rsp_t.addr, rsp_t.wdata});
                end
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                repeat (rsp_dly) @(negedge clk);
                if (resp_en) begin
                    if (rsp_t.wen) begin
                        bus_mem[rsp_t.addr >> 3] = merge(bus_rd(rsp_t.addr >> 3), rsp_t.wdata, rsp_t.wmask);
                        mem_rdata = 64'h0;
                    end else begin
                        mem_rdata = bus_rd(rsp_t.addr >> 3);
                    end
                    mem_rvalid = 1'b1;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // mode 0: normal fetch; mode 1/2: if_flush pulsed once ifetch_en is seen
    task automatic do_fetch(input logic [63:0] addr, input int mode);
        int          start, iv0;
        bit          seen;
        bus_t        t;
        logic [63:0] w;
        logic [31:0] exp_i;
        bus_q.delete();
        w     = ref_rd(addr >> 3);
        exp_i = addr[2] ? w[63:32] : w[31:0];
        iv0   = n_iv;
        start = cyc;
        if_addr = addr;
        if_req  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = ifetch_en; end
        check("ifetch_en_seen", seen, 1);
        lat_en = cyc - start;
        if_req = 1'b0;
        if (mode != 0) begin
            if_flush = 1'b1;
            @(negedge clk);
            if_flush = 1'b0;
            repeat (12) @(negedge clk);
            check("stale_dropped", n_iv - iv0, 0);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = (n_iv != iv0); end
            check("instr_valid_seen", seen, 1);
            lat_iv = cyc - start;
            check("instr", instr, exp_i);
            repeat (2) @(negedge clk);
            check("instr_valid_once", n_iv - iv0, 1);
        end
        if (bus_q.size() > 0) begin
            t = bus_q.pop_front();
            check("if_bus", {t.addr, t.wen, t.wmask}, {addr, 1'b0, 8'h00});
        end else begin
            check("if_bus_count", bus_q.size(), 1);
        end
    endtask

    task automatic do_ls(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask);
        bit          seen;
        bus_t        t;
        logic [63:0] old;
        bus_q.delete();
        old = ref_rd(addr >> 3);
        ls_wen = wen; ls_addr = addr; ls_wdata = wdata; ls_wmask = wmask;
        ls_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = ls_done; end
        check("ls_done_seen", seen, 1);
        ls_req = 1'b0;
        if (wen) ref_mem[addr >> 3] = merge(old, wdata, wmask);
        else     check("ls_rdata", ls_rdata, old);
        if (bus_q.size() > 0) begin
            t = bus_q.pop_front();
            check("ls_bus", {t.addr, t.wen, t.wmask}, {addr, wen, wen ? wmask : 8'h00});
            if (wen) check("ls_bus_wdata", t.wdata, wdata);
        end else begin
            check("ls_bus_count", bus_q.size(), 1);
        end
    endtask

    initial begin
        int          d0, starve, t0;
        bit          seen, exp_if;
        logic [63:0] a;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 64'h0; if_flush = 1'b0;
        ls_req = 1'b0; ls_wen = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {ifetch_en, instr_valid, instr, ls_rdata, ls_done, mem_valid,
                                mem_wen, mem_addr, mem_wdata, mem_wmask, bus_err}, 256'h0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch with minimum latency; upper word selected by addr[2]
        ref_mem[(RESET_PC + 64'h4) >> 3] = 64'h00A0_0093_0000_0013;
        bus_mem[(RESET_PC + 64'h4) >> 3] = 64'h00A0_0093_0000_0013;
        rdy_dly = 0; rsp_dly = 0;
        do_fetch(RESET_PC + 64'h4, 0);
        check("lat_ifetch_en", lat_en, 2);
        check("lat_instr_valid", lat_iv, 3);
        do_fetch(RESET_PC, 0);

        // Store with ready held off for three cycles, then read it back
        rdy_dly = 3;
        do_ls(1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF);
        check("store_valid_cycles", valid_cycles, 4);
        rdy_dly = 1; rsp_dly = 2;
        do_ls(1'b1, 64'h8000_1000, 64'hAABB_CCDD_EEFF_0011, 8'h0F);
        do_ls(1'b0, 64'h8000_1000, 64'h0, 8'h0);

        // Both requesters held: LS wins until the starve limit is reached
        rdy_dly = 0; rsp_dly = 0;
        bus_q.delete();
        if_addr = 64'h8000_0100; ls_addr = 64'h9000_0000; ls_wen = 1'b0; ls_wmask = 8'h0;
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 200 && bus_q.size() < 7; i++) @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        check("starve_grants", bus_q.size() >= 7, 1);
        starve = 0;
        for (int k = 0; k < 7 && k < bus_q.size(); k++) begin
            exp_if = (starve == c_STARVE_MAX);
            if (exp_if) starve = 0;
            else        starve = (starve < c_STARVE_MAX) ? starve + 1 : c_STARVE_MAX;
            check($sformatf("grant_order_%0d", k), bus_q[k].addr,
                  exp_if ? 64'h8000_0100 : 64'h9000_0000);
        end
        repeat (10) @(negedge clk);

        // Redirects: during wait, coincident with the response, and in IDLE
        rsp_dly = 3;
        do_fetch(64'h8000_0200, 1);
        rsp_dly = 0;
        do_fetch(64'h8000_0204, 2);
        if_flush = 1'b1; @(negedge clk); if_flush = 1'b0;
        do_fetch(64'h8000_0208, 0);

        // Random traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            rdy_dly = $urandom_range(0, 3);
            rsp_dly = $urandom_range(0, 3);
            a = 64'h8000_2000 + 64'(($urandom_range(0, 15)) << 3);
            case ($urandom_range(0, 2))
                0:       do_fetch(a + 64'(($urandom_range(0, 1)) << 2), 0);
                1:       do_ls(1'b0, a, 64'h0, 8'h0);
                default: do_ls(1'b1, a, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
            endcase
        end

        // Asynchronous reset while a load waits for its response
        rdy_dly = 0; rsp_dly = 6;
        bus_q.delete();
        ls_wen = 1'b0; ls_addr = 64'h8000_2008; ls_req = 1'b1;
        for (int i = 0; i < 20 && bus_q.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1; ls_req = 1'b0;
        #1;
        check("async_reset_outputs", {ifetch_en, instr_valid, instr, ls_rdata, ls_done, mem_valid,
                                      mem_wen, mem_addr, mem_wdata, mem_wmask, bus_err}, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (12) @(negedge clk);
        check("late_rvalid_ignored", n_done - d0, 0);
        rsp_dly = 0;
        do_ls(1'b0, 64'h8000_2010, 64'h0, 8'h0);

`ifdef ARB_BUS_TIMEOUT_EN
        // Fetch whose response never arrives
        resp_en = 1'b0;
        if_addr = 64'h8000_0040; if_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = ifetch_en; end
        check("to_ifetch_en", seen, 1);
        if_req = 1'b0;
        t0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = instr_valid; end
        check("to_instr_valid", seen, 1);
        check("to_latency", cyc - t0, 8);
        check("to_instr", instr, NOP_INSTR);
        check("to_bus_err", bus_err, 1);
        check("to_idle", mem_valid, 0);
        repeat (3) @(negedge clk);
        check("to_bus_err_sticky", bus_err, 1);
        resp_en = 1'b1;
`else
        t0 = cyc;
        check("bus_err_tied", bus_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
